// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, reset/exception vectors and the fs-to-ds payload layout.
package if_stage_pkg;
    localparam logic [31:0] RESET_PC         = 32'hbfc00000;
    localparam logic [31:0] EXCP_ENTRY       = 32'hbfc00380;
    localparam int          BR_BUS_WD        = 33;
    localparam int          CP0_TO_FS_BUS_WD = 34;
    localparam int          FS_TO_DS_BUS_WD  = 102;
    localparam logic [4:0]  EX_ADEL          = 5'h04;

    typedef struct packed {
        logic        excp;
        logic [4:0]  execode;
        logic [31:0] badvaddr;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: synchronous instruction SRAM port between the fetch stage (master) and the memory (slave).
interface if_stage_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  inst_sram_rdata
    );
    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output inst_sram_rdata
    );
endinterface

// File: rtl/if_stage_fs_inst_buf.sv
// fs_inst_buf: single-entry holding register that keeps the fetched word alive across decode stalls.
module fs_inst_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cap_i,
    input  logic        clr_i,
    input  logic [31:0] rdata_i,
    output logic        valid_o,
    output logic [31:0] inst_o
);
    logic        valid_q;
    logic [31:0] data_q;

    // only the first stalled cycle carries the real SRAM word; later ones are stale
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (cap_i && !valid_q) begin
            valid_q <= 1'b1;
            data_q  <= rdata_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = valid_q ? data_q : rdata_i;
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage -- PC register, next-PC selection, SRAM request and fs-to-ds payload.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ds_allowin,
    input  logic [BR_BUS_WD-1:0]        br_bus,
    input  logic [CP0_TO_FS_BUS_WD-1:0] cp0_to_fs_bus,
    output logic                        fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
    if_stage_if.master                  inst_sram
);
    logic        to_fs_valid_q, fs_valid_q, br_pend_q;
    logic        fs_valid_d, br_pend_d;
    logic [31:0] fs_pc_q, fs_pc_d, br_pend_target_q, br_pend_target_d;
    logic        br_taken, excp_flush, eret_flush, flush;
    logic [31:0] br_target, epc, nextpc, buf_inst;
    logic        fs_allowin, advance, stall, ibuf_valid, adel;
    fs_to_ds_t   ds_bus;

    assign {br_taken, br_target}          = br_bus;
    assign {excp_flush, eret_flush, epc}  = cp0_to_fs_bus;
    assign flush      = excp_flush | eret_flush;
    assign fs_allowin = !fs_valid_q | ds_allowin;
    assign advance    = to_fs_valid_q & (fs_allowin | flush);
    assign stall      = fs_valid_q & !fs_allowin;

    assign nextpc = excp_flush ? EXCP_ENTRY :
                    eret_flush ? epc :
                    br_pend_q  ? br_pend_target_q :
                    br_taken   ? br_target : fs_pc_q + 32'd4;

    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        br_pend_d        = br_pend_q;
        br_pend_target_d = br_pend_target_q;
        if (advance) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
            br_pend_d  = 1'b0;
        end else if (stall && !flush && br_taken) begin
            // decode may drop br_taken before we advance, so remember the target
            br_pend_d        = 1'b1;
            br_pend_target_d = br_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_fs_valid_q    <= 1'b0;
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - 32'd4;
            br_pend_q        <= 1'b0;
            br_pend_target_q <= '0;
        end else begin
            to_fs_valid_q    <= 1'b1;
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            br_pend_q        <= br_pend_d;
            br_pend_target_q <= br_pend_target_d;
        end
    end

    fs_inst_buf u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .cap_i   (stall),
        .clr_i   (advance),
        .rdata_i (inst_sram.inst_sram_rdata),
        .valid_o (ibuf_valid),
        .inst_o  (buf_inst)
    );

    assign adel            = fs_pc_q[1:0] != 2'b00;
    assign ds_bus.excp     = adel;
    assign ds_bus.execode  = adel ? EX_ADEL : 5'h00;
    assign ds_bus.badvaddr = adel ? fs_pc_q : 32'h0;
    assign ds_bus.inst     = adel ? 32'h0 : buf_inst;
    assign ds_bus.pc       = fs_pc_q;
    assign fs_to_ds_bus    = ds_bus;
    assign fs_to_ds_valid  = fs_valid_q & !flush;

    assign inst_sram.inst_sram_en    = advance;
    assign inst_sram.inst_sram_wen   = 4'b0000;
    assign inst_sram.inst_sram_addr  = nextpc;
    assign inst_sram.inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus for if_stage, checked every cycle against a fetch-level model plus literal spot checks.
module tb_if_stage;
    import if_stage_pkg::*;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        ds_allowin;
    logic [BR_BUS_WD-1:0]        br_bus;
    logic [CP0_TO_FS_BUS_WD-1:0] cp0;
    logic                        fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus;
    int                          n_chk = 0;
    int                          n_fail = 0;

    if_stage_if sram ();

    if_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .cp0_to_fs_bus  (cp0),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram      (sram)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a == 32'hbfc00010) ? 32'h11111111 : (a ^ 32'h3c3c5a5a);
    endfunction

    // SRAM answers one cycle after an enabled request, otherwise returns junk
    always @(posedge clk)
        sram.inst_sram_rdata <= sram.inst_sram_en ? memw(sram.inst_sram_addr) : $urandom;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic peek;
        @(negedge clk);
        #2;
    endtask

    // Model: what has been fetched, from which PC, and which redirect is owed
    initial begin
        logic        mtv, mv, mbp, fl, allow, go, ad;
        logic [31:0] mpc, mbt, np;
        mtv = 0; mv = 0; mbp = 0; mpc = RESET_PC - 32'd4; mbt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!resetn) begin
                mtv = 0; mv = 0; mbp = 0; mbt = 0; mpc = RESET_PC - 32'd4;
            end
            fl    = cp0[33] | cp0[32];
            allow = !mv | ds_allowin;
            np    = cp0[33] ? EXCP_ENTRY : cp0[32] ? cp0[31:0] : mbp ? mbt :
                    br_bus[32] ? br_bus[31:0] : mpc + 32'd4;
            go    = mtv & (allow | fl);
            chk("m_en", 128'(sram.inst_sram_en), 128'(go));
            chk("m_wen", 128'(sram.inst_sram_wen), 128'(0));
            if (go) chk("m_addr", 128'(sram.inst_sram_addr), 128'(np));
            chk("m_valid", 128'(fs_to_ds_valid), 128'(mv & !fl));
            if (mv && !fl) begin
                ad = mpc[1:0] != 0;
                chk("m_bus", 128'(fs_to_ds_bus),
                    128'({ad, ad ? 5'h04 : 5'h00, ad ? mpc : 32'h0, ad ? 32'h0 : memw(mpc), mpc}));
            end
            if (resetn) begin
                if (go) begin
                    mv = 1; mpc = np; mbp = 0;
                end else if (mv && !allow && br_bus[32]) begin
                    mbp = 1; mbt = br_bus[31:0];
                end
                mtv = 1;
            end
        end
    end

    initial begin
        resetn = 0; ds_allowin = 1; br_bus = '0; cp0 = '0;
        step; step; peek;
        chk("rst_valid", 128'(fs_to_ds_valid), 128'(0));
        chk("rst_en", 128'(sram.inst_sram_en), 128'(0));
        step; resetn = 1;
        peek; chk("tv0_en", 128'(sram.inst_sram_en), 128'(0));
        step; peek;
        chk("first_en", 128'(sram.inst_sram_en), 128'(1));
        chk("first_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00000));
        step; peek;
        chk("first_valid", 128'(fs_to_ds_valid), 128'(1));
        chk("pc0", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00000));
        step; peek; chk("pc1", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00004));
        step; peek; chk("pc2", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00008));
        step; step; ds_allowin = 0;
        for (int i = 0; i < 3; i++) begin
            peek;
            chk("stall_pc", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00010));
            chk("stall_inst", 128'(fs_to_ds_bus[63:32]), 128'(32'h11111111));
            chk("stall_en", 128'(sram.inst_sram_en), 128'(0));
            step;
        end
        ds_allowin = 1;
        peek; chk("rel_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00014));
        step; ds_allowin = 0; br_bus = {1'b1, 32'hbfc00100};
        peek; chk("rel_pc", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00014));
        step; br_bus = '0;
        peek; chk("br_stall_en", 128'(sram.inst_sram_en), 128'(0));
        step; ds_allowin = 1;
        peek;
        chk("br_pend_en", 128'(sram.inst_sram_en), 128'(1));
        chk("br_pend_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00100));
        step; ds_allowin = 0;
        peek; chk("br_pc", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00100));
        step; cp0 = {2'b10, 32'h0};
        peek;
        chk("ex_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00380));
        chk("ex_valid", 128'(fs_to_ds_valid), 128'(0));
        chk("ex_en", 128'(sram.inst_sram_en), 128'(1));
        step; cp0 = '0;
        peek;
        chk("ex_pc", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00380));
        chk("ex_inst_live", 128'(fs_to_ds_bus[63:32]), 128'(memw(32'hbfc00380)));
        step; ds_allowin = 1; cp0 = {2'b01, 32'hbfc00022};
        peek; chk("eret_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00022));
        step; cp0 = '0;
        peek;
        chk("adel_excp", 128'(fs_to_ds_bus[101]), 128'(1));
        chk("adel_code", 128'(fs_to_ds_bus[100:96]), 128'(5'h04));
        chk("adel_bad", 128'(fs_to_ds_bus[95:64]), 128'(32'hbfc00022));
        chk("adel_inst", 128'(fs_to_ds_bus[63:32]), 128'(0));
        step; cp0 = {2'b11, 32'h80000000};
        peek; chk("both_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00380));
        step; cp0 = '0;
        peek; chk("both_pc", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00380));
        step; ds_allowin = 0;
        step; step; resetn = 0;
        #1;
        chk("arst_valid", 128'(fs_to_ds_valid), 128'(0));
        chk("arst_en", 128'(sram.inst_sram_en), 128'(0));
        step; resetn = 1;
        peek; chk("re_tv0_en", 128'(sram.inst_sram_en), 128'(0));
        step; peek;
        chk("re_addr", 128'(sram.inst_sram_addr), 128'(32'hbfc00000));
        chk("re_en", 128'(sram.inst_sram_en), 128'(1));
        step; ds_allowin = 1;
        peek; chk("re_pc", 128'(fs_to_ds_bus[31:0]), 128'(32'hbfc00000));
        step; step; peek;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
